sha_msg_padder: RTL and testbench

- Upstream stage of the SHA-256 message scheduler.
- Accepts an arbitrary-length message as a byte stream with valid/ready/last handshaking.
- Packs bytes big-endian into 32-bit words and applies FIPS 180-4 padding: 0x80 byte, zero fill, then the 64-bit bit-length.
- Emits exactly 16 words per 512-bit block on M_o/M_dv, gated at block boundaries by a downstream block-ready signal.

---
 rtl/sha_pkg.sv | 19 +
 rtl/sha_byte_packer.sv | 25 ++
 rtl/sha_msg_padder.sv | 195 +++++++++++++++++++
 tb/tb_sha_msg_padder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 types and constants used by the padder, message scheduler
// and round engine.
package sha_pkg;

  typedef logic [31:0] word_t;

  localparam int         WORDS_PER_BLK = 16;
  localparam logic [7:0] PAD_BYTE      = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PAD,
    ST_ZERO,
    ST_LEN_HI,
    ST_LEN_LO
  } pad_state_t;

endpackage

// File: rtl/sha_byte_packer.sv
// Big-endian byte lane insertion for the SHA padder: places an incoming byte
// or the 0x80 pad marker at byte position pos of the partial word.
module sha_byte_packer
  import sha_pkg::*;
(
  input  word_t      partial,
  input  logic [1:0] pos,
  input  logic [7:0] data,
  output word_t      word_ins,
  output word_t      word_pad,
  output logic       word_full
);

  // Position 0 is the most significant lane; lanes after the pad marker are zeroed.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE_POS = 2'(3 - gi);

    assign word_ins[gi*8 +: 8] = (pos == LANE_POS) ? data : partial[gi*8 +: 8];
    assign word_pad[gi*8 +: 8] = (pos == LANE_POS) ? PAD_BYTE :
                                 (LANE_POS < pos)  ? partial[gi*8 +: 8] : 8'h00;
  end

  assign word_full = (pos == 2'd3);

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 32-bit words and appends
// 0x80, zero fill and the 64-bit bit length. Optional SHA_PAD_LEN_OVF_EN adds len_ovf.
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_vld,
  input  logic        in_last,
  input  logic        in_msg_empty,
  output logic        in_rdy,
  input  logic        blk_rdy,
  output logic [31:0] M_o,
  output logic        M_dv,
  output logic        blk_first,
  output logic        blk_last,
`ifdef SHA_PAD_LEN_OVF_EN
  output logic        len_ovf,
`endif
  output logic        msg_done
);

  localparam logic [3:0] WIDX_LAST = 4'(WORDS_PER_BLK - 1);
  localparam logic [3:0] WIDX_LEN  = 4'(WORDS_PER_BLK - 2);

  pad_state_t       state_reg;
  logic [1:0]       pos_reg;
  logic [3:0]       widx_reg;
  word_t            part_reg;
  logic [LEN_W-1:0] len_reg;
  logic             armed_reg;

  word_t            m_o_reg;
  logic             m_dv_reg;
  logic             blk_first_reg;
  logic             blk_last_reg;
  logic             msg_done_reg;

  word_t            word_ins;
  word_t            word_pad;
  logic             word_full;
  logic             accept;
  logic             at_blk_start;
  logic             gate_ok;
  logic             emit;
  word_t            emit_word;
  logic [3:0]       widx_next;
  logic [LEN_W-1:0] len_next;
  logic [63:0]      len_ext;

  sha_byte_packer u_packer (
    .partial   (part_reg),
    .pos       (pos_reg),
    .data      (in_data),
    .word_ins  (word_ins),
    .word_pad  (word_pad),
    .word_full (word_full)
  );

`ifdef SHA_PAD_LEN_OVF_EN
  logic [LEN_W:0] len_sum;
  logic           len_wrap;
  logic           len_ovf_reg;

  assign len_sum  = {1'b0, len_reg} + (LEN_W+1)'(8);
  assign len_wrap = len_sum[LEN_W];
  assign len_next = len_wrap ? '1 : len_sum[LEN_W-1:0];
  assign len_ovf  = len_ovf_reg;
`else
  assign len_next = len_reg + LEN_W'(8);
`endif

  assign len_ext      = 64'(len_reg);
  assign widx_next    = widx_reg + 4'd1;
  assign at_blk_start = (pos_reg == 2'd0) && (widx_reg == 4'd0);
  // Word 0 of every block waits for the downstream block-ready.
  assign gate_ok      = (widx_reg != 4'd0) || blk_rdy;
  assign accept       = in_vld && in_rdy;

  // armed_reg keeps in_rdy low for the first cycle out of reset.
  always_comb begin
    in_rdy = 1'b0;
    if (armed_reg) begin
      case (state_reg)
        ST_IDLE:   in_rdy = blk_rdy;
        ST_ABSORB: in_rdy = !at_blk_start || blk_rdy;
        default:   in_rdy = 1'b0;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_word = '0;
    case (state_reg)
      ST_ABSORB: if (accept && word_full) begin
        emit      = 1'b1;
        emit_word = word_ins;
      end
      ST_PAD: if (gate_ok) begin
        emit      = 1'b1;
        emit_word = word_pad;
      end
      ST_ZERO: if (gate_ok) begin
        emit      = 1'b1;
        emit_word = '0;
      end
      ST_LEN_HI: begin
        emit      = 1'b1;
        emit_word = len_ext[63:32];
      end
      ST_LEN_LO: begin
        emit      = 1'b1;
        emit_word = len_ext[31:0];
      end
      default: emit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pos_reg       <= 2'd0;
      widx_reg      <= 4'd0;
      part_reg      <= '0;
      len_reg       <= '0;
      armed_reg     <= 1'b0;
      m_o_reg       <= '0;
      m_dv_reg      <= 1'b0;
      blk_first_reg <= 1'b0;
      blk_last_reg  <= 1'b0;
      msg_done_reg  <= 1'b0;
`ifdef SHA_PAD_LEN_OVF_EN
      len_ovf_reg   <= 1'b0;
`endif
    end else begin
      armed_reg     <= 1'b1;
      m_dv_reg      <= emit;
      blk_first_reg <= emit && (widx_reg == 4'd0);
      blk_last_reg  <= emit && (widx_reg == WIDX_LAST);
      msg_done_reg  <= emit && (state_reg == ST_LEN_LO);
      if (emit) begin
        m_o_reg  <= emit_word;
        widx_reg <= widx_next;
      end

      case (state_reg)
        ST_IDLE: if (accept) begin
`ifdef SHA_PAD_LEN_OVF_EN
          len_ovf_reg <= 1'b0;
`endif
          if (in_msg_empty) begin
            state_reg <= ST_PAD;
          end else begin
            part_reg  <= word_ins;
            pos_reg   <= pos_reg + 2'd1;
            len_reg   <= len_next;
            state_reg <= in_last ? ST_PAD : ST_ABSORB;
          end
        end
        ST_ABSORB: if (accept) begin
          part_reg <= word_full ? '0 : word_ins;
          pos_reg  <= pos_reg + 2'd1;
          len_reg  <= len_next;
`ifdef SHA_PAD_LEN_OVF_EN
          if (len_wrap) len_ovf_reg <= 1'b1;
`endif
          if (in_last) state_reg <= ST_PAD;
        end
        ST_PAD: if (emit) begin
          part_reg  <= '0;
          pos_reg   <= 2'd0;
          state_reg <= (widx_next == WIDX_LEN) ? ST_LEN_HI : ST_ZERO;
        end
        ST_ZERO: if (emit && (widx_next == WIDX_LEN)) state_reg <= ST_LEN_HI;
        ST_LEN_HI: state_reg <= ST_LEN_LO;
        ST_LEN_LO: begin
          state_reg <= ST_IDLE;
          len_reg   <= '0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign M_o       = m_o_reg;
  assign M_dv      = m_dv_reg;
  assign blk_first = blk_first_reg;
  assign blk_last  = blk_last_reg;
  assign msg_done  = msg_done_reg;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Randomized bench for sha_msg_padder: every message is compared word by word
// against a padded-byte-stream reference built from the padding rules.
module tb_sha_msg_padder;

  typedef logic [7:0]  bq_t [$];
  typedef logic [34:0] wq_t [$];

  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_vld = 1'b0;
  logic        in_last = 1'b0;
  logic        in_msg_empty = 1'b0;
  logic        blk_rdy = 1'b1;
  logic        in_rdy;
  logic [31:0] M_o;
  logic        M_dv;
  logic        blk_first;
  logic        blk_last;
  logic        msg_done;
`ifdef SHA_PAD_LEN_OVF_EN
  logic        len_ovf;
`endif

  int  total = 0;
  int  bad = 0;
  bq_t msg_q;
  wq_t mon_q;

  sha_msg_padder dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_vld       (in_vld),
    .in_last      (in_last),
    .in_msg_empty (in_msg_empty),
    .in_rdy       (in_rdy),
    .blk_rdy      (blk_rdy),
    .M_o          (M_o),
    .M_dv         (M_dv),
    .blk_first    (blk_first),
    .blk_last     (blk_last),
`ifdef SHA_PAD_LEN_OVF_EN
    .len_ovf      (len_ovf),
`endif
    .msg_done     (msg_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (M_dv) mon_q.push_back({blk_first, blk_last, msg_done, M_o});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: message || 0x80 || zeros || 64-bit bit length, cut into words.
  function automatic wq_t ref_words(input bq_t m);
    bq_t         p;
    wq_t         r;
    logic [63:0] bits;
    int          nw;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nw = p.size() / 4;
    for (int i = 0; i < nw; i++)
      r.push_back({1'(i % 16 == 0), 1'(i % 16 == 15), 1'(i == nw - 1),
                   p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_in_rdy"}, 64'(in_rdy), 64'd0);
    chk({tag, "_dv"}, 64'(M_dv), 64'd0);
    chk({tag, "_m_o"}, 64'(M_o), 64'd0);
    chk({tag, "_flags"}, 64'({blk_first, blk_last, msg_done}), 64'd0);
  endtask

  task automatic fill_seq(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(255)));
  endtask

  // Sends msg_q; hold>0 keeps blk_rdy low that many cycles before the first
  // byte and after the last byte, checking that nothing crosses the boundary.
  task automatic send_msg(input string name, input int gap_pct, input bit rnd_rdy, input int hold);
    wq_t exp_q;
    int  n, need, idx, cyc;
    bit  acc;
    n = msg_q.size();
    need = (n == 0) ? 1 : n;
    exp_q = ref_words(msg_q);
    mon_q.delete();
    idx = 0;
    cyc = 0;
    if (hold > 0) begin
      blk_rdy = 1'b0;
      in_vld = 1'b1;
      in_msg_empty = (n == 0);
      in_data = (n == 0) ? 8'h00 : msg_q[0];
      in_last = (n == 1);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk({name, "_hold0_in_rdy"}, 64'(in_rdy), 64'd0);
        chk({name, "_hold0_first"}, 64'(M_dv && blk_first), 64'd0);
        @(posedge clk); #1;
      end
      blk_rdy = 1'b1;
    end
    while (idx < need && cyc < BUDGET) begin
      in_vld = ($urandom_range(99) >= gap_pct);
      in_msg_empty = (n == 0);
      in_data = (n == 0) ? 8'($urandom_range(255)) : msg_q[idx];
      in_last = (n == 0) ? 1'($urandom_range(1)) : (idx == n - 1);
      if (rnd_rdy) blk_rdy = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = in_vld && in_rdy;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    in_vld = 1'b0;
    in_last = 1'b0;
    in_msg_empty = 1'b0;
    if (idx < need) chk({name, "_in_timeout"}, 64'(idx), 64'(need));
    if (hold > 0) begin
      blk_rdy = 1'b0;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk({name, "_hold1_in_rdy"}, 64'(in_rdy), 64'd0);
        chk({name, "_hold1_first"}, 64'(M_dv && blk_first), 64'd0);
        @(posedge clk); #1;
      end
      blk_rdy = 1'b1;
    end
    while (mon_q.size() < exp_q.size() && cyc < BUDGET) begin
      if (rnd_rdy) blk_rdy = ($urandom_range(3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    blk_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk($sformatf("%s_w%0d", name, i), 64'(mon_q[i]), 64'(exp_q[i]));
    $display("msg %s len=%0d words=%0d total=%0d bad=%0d", name, n, mon_q.size(), total, bad);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx, cyc;
    bit  acc;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("reset");

    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg("abc", 0, 1'b0, 0);

    msg_q.delete();
    send_msg("empty", 0, 1'b0, 0);

    fill_seq(55);
    send_msg("len55", 0, 1'b0, 0);

    fill_seq(56);
    send_msg("len56", 0, 1'b0, 0);

    fill_seq(64);
    send_msg("len64_hold", 0, 1'b0, 10);

    fill_seq(40);
    idx = 0;
    cyc = 0;
    while (idx < 20 && cyc < BUDGET) begin
      in_vld = 1'b1;
      in_data = msg_q[idx];
      in_last = 1'b0;
      @(negedge clk);
      acc = in_vld && in_rdy;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    chk("mid_bytes", 64'(idx), 64'd20);
    in_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle("mid_rst");
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg("abc_after_rst", 0, 1'b0, 0);

    for (int r = 0; r < 10; r++) begin
      fill_rand($urandom_range(0, 130));
      send_msg($sformatf("rnd%0d", r), 30, 1'b1, 0);
    end

    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg("abc_tail", 20, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
